// File: rtl/mem_port_arbiter.sv
// N-port arbiter in front of one shared memory port. Each granted access runs
// to completion; its response and read data are then held per port until that stage loads.
module mem_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS-1:0]          req_read,
    input  logic [NUM_PORTS-1:0]          req_write,
    input  logic [NUM_PORTS*DATA_W/8-1:0] req_wmask,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_address,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    input  logic [NUM_PORTS-1:0]          pipe_load,
    output logic [NUM_PORTS-1:0]          req_resp,
    output logic [NUM_PORTS*DATA_W-1:0]  req_rdata,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [DATA_W/8-1:0]           mem_wmask,
    output logic [ADDR_W-1:0]             mem_address,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_resp,
    input  logic [DATA_W-1:0]             mem_rdata
);
    localparam int MASK_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0] done_q, done_d;
    logic                 op_write_q, op_write_d;
    logic [MASK_W-1:0]    wmask_q, wmask_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    rdata_buf_q [NUM_PORTS];
    logic [DATA_W-1:0]    rdata_buf_d [NUM_PORTS];

    logic [NUM_PORTS-1:0] eligible;
    logic                 found;
    logic [IDX_W-1:0]     winner;

    // A port whose response is still waiting to be consumed is never re-granted.
    always_comb begin
        eligible = (req_read | req_write) & ~done_q;
        found    = 1'b0;
        winner   = '0;
        if (PRIO_MODE == 1) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    found  = 1'b1;
                    winner = IDX_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (!found && eligible[i] && ((int'(rr_ptr_q) + k) % NUM_PORTS == i)) begin
                        found  = 1'b1;
                        winner = IDX_W'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        done_d      = done_q;
        op_write_d  = op_write_q;
        wmask_d     = wmask_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_buf_d = rdata_buf_q;

        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pipe_load[i] && done_q[i]) done_d[i] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = BUSY;
                    grant_d  = winner;
                    rr_ptr_d = (winner == IDX_W'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (winner == IDX_W'(i)) begin
                            op_write_d = req_write[i];
                            wmask_d    = req_wmask[i*MASK_W +: MASK_W];
                            addr_d     = req_address[i*ADDR_W +: ADDR_W];
                            wdata_d    = req_wdata[i*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            BUSY: begin
                // Setting done here overrides a same-cycle pipe_load clear.
                if (mem_resp) begin
                    state_d = IDLE;
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (grant_q == IDX_W'(i)) begin
                            done_d[i] = 1'b1;
                            if (!op_write_q) rdata_buf_d[i] = mem_rdata;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            done_q     <= '0;
            op_write_q <= 1'b0;
            wmask_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            for (int i = 0; i < NUM_PORTS; i++) rdata_buf_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            done_q      <= done_d;
            op_write_q  <= op_write_d;
            wmask_q     <= wmask_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    assign mem_read    = (state_q == BUSY) && !op_write_q;
    assign mem_write   = (state_q == BUSY) && op_write_q;
    assign mem_wmask   = wmask_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign req_resp    = done_q;

    always_comb begin
        req_rdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) req_rdata[i*DATA_W +: DATA_W] = rdata_buf_q[i];
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a 2-port round-robin instance and a 3-port fixed-priority instance.
module tb_mem_port_arbiter;
    logic clk;
    logic reset_n;

    // 2-port round-robin instance
    logic [1:0]  rr_read, rr_write, rr_pl, rr_resp;
    logic [7:0]  rr_wmask;
    logic [63:0] rr_addr, rr_wdata, rr_rdata;
    logic        rr_mread, rr_mwrite, rr_mresp;
    logic [3:0]  rr_mwmask;
    logic [31:0] rr_maddr, rr_mwdata, rr_mrdata;

    // 3-port fixed-priority instance
    logic [2:0]  fp_read, fp_write, fp_pl, fp_resp;
    logic [11:0] fp_wmask;
    logic [95:0] fp_addr, fp_wdata, fp_rdata;
    logic        fp_mread, fp_mwrite, fp_mresp;
    logic [3:0]  fp_mwmask;
    logic [31:0] fp_maddr, fp_mwdata, fp_mrdata;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .PRIO_MODE(0)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .req_read(rr_read), .req_write(rr_write), .req_wmask(rr_wmask),
        .req_address(rr_addr), .req_wdata(rr_wdata), .pipe_load(rr_pl),
        .req_resp(rr_resp), .req_rdata(rr_rdata),
        .mem_read(rr_mread), .mem_write(rr_mwrite), .mem_wmask(rr_mwmask),
        .mem_address(rr_maddr), .mem_wdata(rr_mwdata),
        .mem_resp(rr_mresp), .mem_rdata(rr_mrdata)
    );

    mem_port_arbiter #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .PRIO_MODE(1)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .req_read(fp_read), .req_write(fp_write), .req_wmask(fp_wmask),
        .req_address(fp_addr), .req_wdata(fp_wdata), .pipe_load(fp_pl),
        .req_resp(fp_resp), .req_rdata(fp_rdata),
        .mem_read(fp_mread), .mem_write(fp_mwrite), .mem_wmask(fp_mwmask),
        .mem_address(fp_maddr), .mem_wdata(fp_mwdata),
        .mem_resp(fp_mresp), .mem_rdata(fp_mrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        rr_read   = '0; rr_write = '0; rr_pl = '0; rr_wmask = '0;
        rr_addr   = '0; rr_wdata = '0; rr_mresp = 1'b0; rr_mrdata = '0;
        fp_read   = '0; fp_write = '0; fp_pl = '0; fp_wmask = '0;
        fp_addr   = '0; fp_wdata = '0; fp_mresp = 1'b0; fp_mrdata = '0;

        // Reset state
        tick(); tick();
        chk("rst_resp", 64'(rr_resp), 64'h0);
        chk("rst_rdata", rr_rdata, 64'h0);
        chk("rst_mread", 64'(rr_mread), 64'h0);
        chk("rst_mwrite", 64'(rr_mwrite), 64'h0);
        chk("rst_maddr", 64'(rr_maddr), 64'h0);
        chk("rst_fp_resp", 64'(fp_resp), 64'h0);
        reset_n = 1'b1;
        tick();

        // Single read on port 0: cycle 0 request, cycle 1..2 mem_read, resp in cycle 2
        rr_read[0] = 1'b1;
        rr_addr[31:0] = 32'h0000_0060;
        #1;
        chk("rd_c0_mread", 64'(rr_mread), 64'h0);
        tick();
        chk("rd_c1_mread", 64'(rr_mread), 64'h1);
        chk("rd_c1_maddr", 64'(rr_maddr), 64'h60);
        tick();
        chk("rd_c2_mread", 64'(rr_mread), 64'h1);
        chk("rd_c2_resp", 64'(rr_resp), 64'h0);
        rr_mresp = 1'b1; rr_mrdata = 32'hDEAD_BEEF;
        tick();
        rr_mresp = 1'b0; rr_mrdata = 32'h0;
        chk("rd_c3_mread", 64'(rr_mread), 64'h0);
        chk("rd_c3_resp", 64'(rr_resp), 64'h1);
        chk("rd_c3_rdata0", 64'(rr_rdata[31:0]), 64'hDEAD_BEEF);
        rr_read[0] = 1'b0;
        tick();
        chk("rd_c4_resp_held", 64'(rr_resp), 64'h1);
        chk("rd_c4_mread", 64'(rr_mread), 64'h0);
        rr_pl[0] = 1'b1;
        tick();
        rr_pl[0] = 1'b0;
        chk("rd_consumed_resp", 64'(rr_resp), 64'h0);
        chk("rd_rdata_kept", 64'(rr_rdata[31:0]), 64'hDEAD_BEEF);

        // pipe_load in the same cycle as mem_resp for port 0
        rr_read[0] = 1'b1;
        rr_addr[31:0] = 32'h0000_0040;
        tick();
        chk("sim_busy_mread", 64'(rr_mread), 64'h1);
        rr_mresp = 1'b1; rr_mrdata = 32'h0BAD_F00D; rr_pl[0] = 1'b1;
        tick();
        rr_mresp = 1'b0; rr_pl[0] = 1'b0; rr_read[0] = 1'b0;
        chk("sim_resp_set", 64'(rr_resp), 64'h1);
        tick();
        chk("sim_resp_hold", 64'(rr_resp), 64'h1);
        chk("sim_rdata0", 64'(rr_rdata[31:0]), 64'h0BAD_F00D);
        rr_pl[0] = 1'b1;
        tick();
        rr_pl[0] = 1'b0;
        chk("sim_resp_clear", 64'(rr_resp), 64'h0);

        // Reset asserted while BUSY
        rr_read[0] = 1'b1;
        rr_addr[31:0] = 32'h0000_0080;
        tick();
        chk("rb_busy_mread", 64'(rr_mread), 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rb_async_mread", 64'(rr_mread), 64'h0);
        chk("rb_async_maddr", 64'(rr_maddr), 64'h0);
        chk("rb_async_rdata", rr_rdata, 64'h0);
        rr_read[0] = 1'b0;
        #1;
        reset_n = 1'b1;
        tick();
        chk("rb_after_resp", 64'(rr_resp), 64'h0);
        chk("rb_after_mread", 64'(rr_mread), 64'h0);

        // Round-robin contention: grants must go 0,1,0,1 (pointer restarted by reset)
        rr_addr  = {32'h0000_2000, 32'h0000_1000};
        rr_read  = 2'b11;
        tick();
        for (int t = 0; t < 4; t++) begin
            chk($sformatf("rr_g%0d_mread", t), 64'(rr_mread), 64'h1);
            chk($sformatf("rr_g%0d_addr", t), 64'(rr_maddr),
                (t % 2 == 0) ? 64'h1000 : 64'h2000);
            rr_mresp = 1'b1; rr_mrdata = 32'hA0 + 32'(t);
            tick();
            rr_mresp = 1'b0;
            chk($sformatf("rr_g%0d_resp", t), 64'(rr_resp), (t % 2 == 0) ? 64'h1 : 64'h2);
            if (t == 3) rr_read = 2'b00;
            rr_pl = (t % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            rr_pl = 2'b00;
        end
        chk("rr_rdata0", 64'(rr_rdata[31:0]), 64'hA2);
        chk("rr_rdata1", 64'(rr_rdata[63:32]), 64'hA3);
        chk("rr_end_idle", 64'(rr_mread), 64'h0);

        // Stall hold: port 1 write, response held 5 cycles, no reissue
        rr_write[1] = 1'b1;
        rr_addr[63:32] = 32'h0000_0100;
        rr_wdata[63:32] = 32'h1234_5678;
        rr_wmask[7:4] = 4'hF;
        tick();
        chk("st_mwrite", 64'(rr_mwrite), 64'h1);
        chk("st_mread", 64'(rr_mread), 64'h0);
        chk("st_maddr", 64'(rr_maddr), 64'h100);
        chk("st_mwdata", 64'(rr_mwdata), 64'h1234_5678);
        chk("st_mwmask", 64'(rr_mwmask), 64'hF);
        rr_mresp = 1'b1; rr_mrdata = 32'hFFFF_0000;
        tick();
        rr_mresp = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("st_hold%0d_resp", c), 64'(rr_resp), 64'h2);
            chk($sformatf("st_hold%0d_mwrite", c), 64'(rr_mwrite), 64'h0);
            tick();
        end
        chk("st_rdata1_kept", 64'(rr_rdata[63:32]), 64'hA3);
        rr_pl[1] = 1'b1; rr_write[1] = 1'b0;
        tick();
        rr_pl[1] = 1'b0;
        chk("st_consumed", 64'(rr_resp), 64'h0);
        chk("st_no_reissue", 64'(rr_mwrite), 64'h0);

        // Fixed priority, 3 ports: 1 and 2 request, then 0 arrives during 1's BUSY
        fp_addr = {32'h0000_2200, 32'h0000_1100, 32'h0000_0A00};
        fp_read = 3'b110;
        tick();
        chk("fp_g1_addr", 64'(fp_maddr), 64'h1100);
        chk("fp_g1_mread", 64'(fp_mread), 64'h1);
        fp_read[0] = 1'b1;
        fp_mresp = 1'b1; fp_mrdata = 32'h1111_1111;
        tick();
        fp_mresp = 1'b0;
        chk("fp_resp_p1", 64'(fp_resp), 64'h2);
        chk("fp_rdata1", 64'(fp_rdata[63:32]), 64'h1111_1111);
        tick();
        chk("fp_g0_addr", 64'(fp_maddr), 64'h0A00);
        chk("fp_g0_p2_wait", 64'(fp_resp[2]), 64'h0);
        fp_mresp = 1'b1; fp_mrdata = 32'h0000_0000;
        tick();
        fp_mresp = 1'b0;
        chk("fp_resp_p01", 64'(fp_resp), 64'h3);
        tick();
        chk("fp_g2_addr", 64'(fp_maddr), 64'h2200);
        chk("fp_g2_mread", 64'(fp_mread), 64'h1);
        fp_mresp = 1'b1; fp_mrdata = 32'h2222_2222;
        tick();
        fp_mresp = 1'b0;
        fp_read = 3'b000;
        chk("fp_resp_all", 64'(fp_resp), 64'h7);
        chk("fp_rdata2", 64'(fp_rdata[95:64]), 64'h2222_2222);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-port memory access arbiter with per-port response latching. It succeeds the per-stage single-port access proxy.
- Sits between pipeline memory clients (IF fetch, MEM load/store, future prefetch/PTW ports) and one shared downstream cache/memory port.
- Arbitrates with round-robin or fixed priority. Captures each granted request, runs it to completion, then holds the response and read data per port until that port's pipe stage advances.

Parameters:
- NUM_PORTS, 2, number of requesting clients; 1..8.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; multiple of 8.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_read  in  NUM_PORTS  per-port read request; level, held until req_resp.
- req_write  in  NUM_PORTS  per-port write request; level, held until req_resp.
- req_wmask  in  NUM_PORTS*DATA_W/8  per-port byte enables; port i at slice i.
- req_address  in  NUM_PORTS*ADDR_W  per-port address.
- req_wdata  in  NUM_PORTS*DATA_W  per-port write data.
- pipe_load  in  NUM_PORTS  per-port stage-advance; consumes the latched response.
- req_resp  out  NUM_PORTS  per-port response; held high until consumed.
- req_rdata  out  NUM_PORTS*DATA_W  per-port latched read data.
- mem_read  out  1  downstream read strobe.
- mem_write  out  1  downstream write strobe.
- mem_wmask  out  DATA_W/8  downstream byte enables.
- mem_address  out  ADDR_W  downstream address.
- mem_wdata  out  DATA_W  downstream write data.
- mem_resp  in  1  downstream completion; one-cycle pulse.
- mem_rdata  in  DATA_W  downstream read data; valid with mem_resp.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; done[], grant, rr_ptr all 0.
  - req_resp=0, req_rdata=0, mem_read=0, mem_write=0, mem_wmask/address/wdata=0.
- Eligibility: port i is eligible when (req_read[i] | req_write[i]) & !done[i].
- IDLE state:
  - If no port is eligible, stay in IDLE.
  - Otherwise select a winner:
    - PRIO_MODE=1: lowest eligible index.
    - PRIO_MODE=0: first eligible index scanning upward from rr_ptr, wrapping modulo NUM_PORTS.
  - At the clock edge: capture winner index, op, wmask, address and wdata into registers. Set rr_ptr = winner+1 (wraps to 0). Go to BUSY.
- BUSY state:
  - mem_read/mem_write driven from the captured op; mem_* from the captured registers, stable for the whole transaction.
  - On mem_resp at the clock edge: drop mem_read/mem_write, set done[grant], write mem_rdata into rdata_buf[grant] (read ops only; write ops keep the previous buffer), go to IDLE.
- req_resp[i] = done[i]. req_rdata slice i = rdata_buf[i].
- done[i] clears at the edge where pipe_load[i]=1 and done[i]=1. pipe_load[i] with done[i]=0 has no effect.
- Latency:
  - Request visible in cycle 0 with arbiter IDLE → mem strobe in cycle 1.
  - mem_resp in cycle k → req_resp in cycle k+1.
  - Minimum of one IDLE cycle between back-to-back downstream transactions.
- A port with done=1 is never re-granted until consumed. A stalled stage therefore never reissues its access.
- Read and write both asserted on one port: write wins; treated as a write.
- Requester deasserts while BUSY on its transaction: the transaction still completes and done is still set. The client must pulse pipe_load to clear it.
- pipe_load[i] in the same cycle as mem_resp for port i: done is set, not cleared; it clears on the next pipe_load.
- mem_resp while in IDLE: ignored.
- Reset asserted mid-transaction: strobes drop immediately and the outstanding downstream access is abandoned. The downstream side must tolerate this.
- NUM_PORTS=1: rr_ptr stays 0; block degenerates to a latched-response proxy.

Test Plan:
- Single read: port0 read addr 0x0000_0060; mem_resp with 0xDEAD_BEEF two cycles after mem_read → mem_read high cycles 1–2, req_resp[0]=1 from cycle 3, rdata0=0xDEAD_BEEF until pipe_load[0], then req_resp[0]=0.
- Round-robin contention, N=2, PRIO_MODE=0: both ports request continuously, pipe_load pulsed on each resp → grant sequence 0,1,0,1; no port is granted twice in a row.
- Fixed priority, N=3, PRIO_MODE=1: ports 1 and 2 request, port 0 idle, then port 0 requests during port 1's BUSY → next grant is port 0, and port 2 waits.
- Stall hold: port1 write addr 0x100, wdata 0x1234_5678, wmask 0xF; pipe_load[1] held low for 5 cycles after resp → req_resp[1] stays 1 and no second mem_write is issued.
- Simultaneous pipe_load and mem_resp for the same port → req_resp rises the next cycle and clears only on a later pipe_load.
- reset_n low during BUSY → mem_read=0 in the same cycle with no clock edge; after release, state IDLE, all req_resp=0, and rr_ptr restarts at port 0.
